fetch_queue: RTL and testbench

Instruction prefetch stage sitting directly upstream of the pipelined MIPS datapath's Fetch/Decode boundary. It owns the fetch PC, issues requests to a variable-latency instruction memory over a req/ack handshake, buffers returned instructions with their PCs in a small FIFO, and presents the head entry to the datapath as `instrF`/`pcF`. Branch/jump redirects from Decode flush the queue and discard any in-flight response.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fq_fifo.sv | 66 ++++++
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction prefetch queue.
package fetch_pkg;

    localparam int          FQ_DEPTH_DEFAULT = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch: the address it came from and the word returned.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    // Fetch FSM: idle, waiting on a live response, waiting on a response to discard.
    typedef enum logic [1:0] {
        FQ_IDLE      = 2'd0,
        FQ_WAIT      = 2'd1,
        FQ_WAIT_DROP = 2'd2
    } fq_state_e;

endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO of fetch entries. Clear wins over push and pop on the same edge.
// The head entry is read straight from the storage registers, so it has no
// combinational dependence on push data. Callers must not pop when empty or
// push when full.
module fq_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  fq_entry_t     push_data_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output fq_entry_t     head_o,
    output logic [CW-1:0] count_o
);

    fq_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: owns the fetch PC, fetches through a single
// outstanding req/ack transaction, buffers {pc, instr} and presents the head
// to Decode. A redirect flushes the queue and discards any in-flight response.
//
// Memory handshake: imem_req is the valid; once raised it stays high with
// imem_addr stable until a rising edge where imem_req && imem_ack, which is the
// single transfer edge (imem_rdata is taken on that edge). imem_ack seen while
// imem_req is low means nothing.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int          DEPTH    = FQ_DEPTH_DEFAULT,
    parameter  logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int          CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    input  logic          stall,
    output logic          instr_valid,
    output logic [31:0]   instrF,
    output logic [31:0]   pcF,
    output logic [31:0]   pcplus4F,
    output fq_state_e     dbg_state_o,
    output logic [CW-1:0] dbg_count_o
);

    fq_state_e   state_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic [31:0] fpc_q;
    logic [31:0] empty_pc_q, empty_pc_d;

    fq_entry_t     head;
    fq_entry_t     push_entry;
    logic [CW-1:0] count;
    logic          acked;
    logic          push;
    logic          pop;
    logic          can_issue;

    // imem_req_q is high exactly while in WAIT or WAIT_DROP.
    assign acked      = imem_req_q && imem_ack;
    assign push       = acked && (state_q == FQ_WAIT) && !redirect;
    assign pop        = (count != '0) && !stall && !redirect;
    // Registered occupancy is used, so a full queue stays blocked even on a pop edge.
    assign can_issue  = (state_q == FQ_IDLE) && !redirect && (count < CW'(DEPTH));
    assign push_entry = '{pc: imem_addr_q, instr: imem_rdata};

    // Fetch FSM with registered request outputs; redirect retargets fpc last so it wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FQ_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            fpc_q       <= RESET_PC;
        end else begin
            case (state_q)
                FQ_IDLE: begin
                    if (can_issue) begin
                        state_q     <= FQ_WAIT;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fpc_q;
                        fpc_q       <= fpc_q + 32'd4;
                    end
                end
                FQ_WAIT: begin
                    if (acked) begin
                        state_q    <= FQ_IDLE;
                        imem_req_q <= 1'b0;
                    end else if (redirect) begin
                        state_q <= FQ_WAIT_DROP;
                    end
                end
                FQ_WAIT_DROP: begin
                    if (acked) begin
                        state_q    <= FQ_IDLE;
                        imem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= FQ_IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
            if (redirect) begin
                fpc_q <= redirect_pc;
            end
        end
    end

    // PC shown while empty tracks the instruction after the last one consumed.
    always_comb begin
        empty_pc_d = empty_pc_q;
        if (pop) begin
            empty_pc_d = head.pc + 32'd4;
        end
    end

    // Empty-queue PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            empty_pc_q <= RESET_PC;
        end else begin
            empty_pc_q <= empty_pc_d;
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .clear_i     (redirect),
        .head_o      (head),
        .count_o     (count)
    );

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = (count != '0);
    assign instrF      = instr_valid ? head.instr : NOP_INSTR;
    assign pcF         = instr_valid ? head.pc : empty_pc_q;
    assign pcplus4F    = pcF + 32'd4;
    assign dbg_state_o = state_q;
    assign dbg_count_o = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a cycle table against a zero-wait memory,
// then hand sequences for fill/stall, redirect-drop and async reset.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instrF, pcF, pcplus4F;
    fq_state_e   dbg_state;
    logic [2:0]  dbg_count;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model: auto mode acks after mem_lat waiting edges; manual mode uses man_ack.
    logic mem_auto = 1'b1;
    int   mem_lat  = 0;
    logic man_ack  = 1'b0;
    int   wait_cnt;
    logic auto_ack;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'd0, a[15:0]};
    endfunction

    assign auto_ack   = imem_req && (wait_cnt == mem_lat);
    assign imem_ack   = mem_auto ? auto_ack : man_ack;
    assign imem_rdata = mem_word(imem_addr);

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset)                    wait_cnt <= 0;
        else if (imem_req && imem_ack) wait_cnt <= 0;
        else if (imem_req)             wait_cnt <= wait_cnt + 1;
    end

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instrF      (instrF),
        .pcF         (pcF),
        .pcplus4F    (pcplus4F),
        .dbg_state_o (dbg_state),
        .dbg_count_o (dbg_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check32({tag, "_req"},    {31'd0, imem_req}, 32'd0);
        check32({tag, "_addr"},   imem_addr, 32'h0);
        check32({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
        check32({tag, "_instr"},  instrF, 32'h0);
        check32({tag, "_pcF"},    pcF, 32'h0);
        check32({tag, "_pcp4"},   pcplus4F, 32'h4);
        check32({tag, "_count"},  {29'd0, dbg_count}, 32'd0);
        check32({tag, "_state"},  32'(dbg_state), 32'(FQ_IDLE));
    endtask

    task automatic do_reset(input logic auto_mode, input int lat);
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        stall       = 1'b0;
        man_ack     = 1'b0;
        mem_auto    = auto_mode;
        mem_lat     = lat;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b1;
    endtask

    // Wait (bounded) for a request, check its address, ack it on the next edge.
    task automatic ack_next(input logic [31:0] exp_addr);
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check32("ack_req_seen", {31'd0, imem_req}, 32'd1);
        check32("ack_addr", imem_addr, exp_addr);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        int          exp_count;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic req, input logic [31:0] addr,
                                input logic v, input logic [31:0] pc, input int cnt);
        vec_t t;
        t.stall     = s;
        t.redir     = r;
        t.rpc       = rpc;
        t.exp_req   = req;
        t.exp_addr  = addr;
        t.exp_valid = v;
        t.exp_pc    = pc;
        t.exp_instr = v ? mem_word(pc) : 32'h0;
        t.exp_count = cnt;
        return t;
    endfunction

    vec_t vecs[14];

    initial begin
        int idx;
        int n;
        logic [31:0] exp_pc;

        // Zero-wait memory, cycle-by-cycle from reset release.
        vecs[0]  = mk(0, 0, 32'h0,   1, 32'h000, 0, 32'h000, 0);
        vecs[1]  = mk(0, 0, 32'h0,   0, 32'h000, 1, 32'h000, 1);
        vecs[2]  = mk(0, 0, 32'h0,   1, 32'h004, 0, 32'h004, 0);
        vecs[3]  = mk(0, 0, 32'h0,   0, 32'h004, 1, 32'h004, 1);
        vecs[4]  = mk(1, 0, 32'h0,   1, 32'h008, 1, 32'h004, 1);
        vecs[5]  = mk(1, 0, 32'h0,   0, 32'h008, 1, 32'h004, 2);
        vecs[6]  = mk(0, 0, 32'h0,   1, 32'h00C, 1, 32'h008, 1);
        vecs[7]  = mk(0, 1, 32'h100, 0, 32'h00C, 0, 32'h008, 0);
        vecs[8]  = mk(0, 0, 32'h0,   1, 32'h100, 0, 32'h008, 0);
        vecs[9]  = mk(0, 0, 32'h0,   0, 32'h100, 1, 32'h100, 1);
        vecs[10] = mk(0, 1, 32'h200, 0, 32'h100, 0, 32'h008, 0);
        vecs[11] = mk(0, 0, 32'h0,   1, 32'h200, 0, 32'h008, 0);
        vecs[12] = mk(0, 0, 32'h0,   0, 32'h200, 1, 32'h200, 1);
        vecs[13] = mk(0, 0, 32'h0,   1, 32'h204, 0, 32'h204, 0);

        do_reset(1'b1, 0);
        for (int i = 0; i < 14; i++) begin
            stall       = vecs[i].stall;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            tick();
            check32($sformatf("v%0d_req", i),   {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            check32($sformatf("v%0d_addr", i),  imem_addr, vecs[i].exp_addr);
            check32($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
            check32($sformatf("v%0d_pcF", i),   pcF, vecs[i].exp_pc);
            check32($sformatf("v%0d_pcp4", i),  pcplus4F, vecs[i].exp_pc + 32'd4);
            check32($sformatf("v%0d_instr", i), instrF, vecs[i].exp_instr);
            check32($sformatf("v%0d_count", i), {29'd0, dbg_count}, 32'(vecs[i].exp_count));
        end
        stall    = 1'b0;
        redirect = 1'b0;

        // Fill under stall with 3-cycle memory, then drain in order.
        do_reset(1'b1, 2);
        stall = 1'b1;
        n = 0;
        while (dbg_count != 3'd4 && n < 60) begin
            tick();
            n++;
        end
        check32("fill_count", {29'd0, dbg_count}, 32'd4);
        repeat (4) tick();
        check32("fill_req_low", {31'd0, imem_req}, 32'd0);
        check32("fill_head_pc", pcF, 32'h0);
        check32("fill_head_instr", instrF, mem_word(32'h0));
        check32("fill_count_hold", {29'd0, dbg_count}, 32'd4);
        stall = 1'b0;
        idx = 0;
        for (int c = 0; c < 30 && idx < 4; c++) begin
            if (instr_valid) begin
                exp_pc = 32'(idx * 4);
                check32($sformatf("drain%0d_pc", idx), pcF, exp_pc);
                check32($sformatf("drain%0d_instr", idx), instrF, mem_word(exp_pc));
                idx++;
            end
            tick();
        end
        check32("drain_seen", 32'(idx), 32'd4);

        // Redirect while the request to 0x10 is outstanding; its data must be dropped.
        do_reset(1'b0, 0);
        ack_next(32'h0);
        ack_next(32'h4);
        ack_next(32'h8);
        stall = 1'b1;
        ack_next(32'hC);
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check32("rd_req_10", imem_addr, 32'h10);
        check32("rd_valid_before", {31'd0, instr_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check32("rd_state_drop", 32'(dbg_state), 32'(FQ_WAIT_DROP));
        check32("rd_req_held", {31'd0, imem_req}, 32'd1);
        check32("rd_addr_held", imem_addr, 32'h10);
        check32("rd_flushed_valid", {31'd0, instr_valid}, 32'd0);
        check32("rd_flushed_count", {29'd0, dbg_count}, 32'd0);
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        check32("rd_after_ack_req", {31'd0, imem_req}, 32'd0);
        check32("rd_after_ack_valid", {31'd0, instr_valid}, 32'd0);
        check32("rd_after_ack_count", {29'd0, dbg_count}, 32'd0);
        check32("rd_after_ack_instr", instrF, 32'h0);
        tick();
        check32("rd_new_req", {31'd0, imem_req}, 32'd1);
        check32("rd_new_addr", imem_addr, 32'h100);
        ack_next(32'h100);
        check32("rd_new_valid", {31'd0, instr_valid}, 32'd1);
        check32("rd_new_pc", pcF, 32'h100);
        check32("rd_new_instr", instrF, mem_word(32'h100));

        // Asynchronous reset in the middle of a wait with a loaded queue.
        do_reset(1'b0, 0);
        stall = 1'b1;
        ack_next(32'h0);
        ack_next(32'h4);
        ack_next(32'h8);
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check32("ar_req_C", imem_addr, 32'hC);
        check32("ar_count3", {29'd0, dbg_count}, 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("ar_now");
        tick();
        check_reset_vals("ar_held");
        reset   = 1'b1;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        check32("ar_first_req", {31'd0, imem_req}, 32'd1);
        check32("ar_first_addr", imem_addr, 32'h0);
        check32("ar_stray_count", {29'd0, dbg_count}, 32'd0);
        check32("ar_stray_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check32("ar_wait_req", {31'd0, imem_req}, 32'd1);
        check32("ar_wait_valid", {31'd0, instr_valid}, 32'd0);
        ack_next(32'h0);
        check32("ar_valid", {31'd0, instr_valid}, 32'd1);
        check32("ar_pc", pcF, 32'h0);
        check32("ar_instr", instrF, mem_word(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
